// File: rtl/fir_iq_scheduler.sv
// fir_iq_scheduler: shares one FIR core between I and Q, re-pairs the results and scales them to OUT_W.
// Define FIR_SAT_EN to clamp out-of-range scaled results; otherwise the low OUT_W bits are kept.
module fir_iq_scheduler #(
    parameter int IN_W    = 18,
    parameter int ACC_W   = 34,
    parameter int OUT_W   = 16,
    parameter int SHIFT   = 15,
    parameter int CLR_CYC = 2
) (
    input  logic                    clk,
    input  logic                    sclr,
    input  logic                    flush,
    input  logic signed [IN_W-1:0]  in_i,
    input  logic signed [IN_W-1:0]  in_q,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    fir_sclr,
    output logic                    fir_nd,
    output logic signed [IN_W-1:0]  fir_din,
    input  logic                    fir_rfd,
    input  logic                    fir_rdy,
    input  logic signed [ACC_W-1:0] fir_dout,
    output logic signed [OUT_W-1:0] out_i,
    output logic signed [OUT_W-1:0] out_q,
    output logic                    out_valid,
    output logic                    order_err
);
    typedef enum logic [1:0] {CLR, IDLE, SEND_I, SEND_Q} state_t;
    localparam int CW = $clog2(CLR_CYC);
    state_t state, state_nx;
    logic [CW-1:0] clr_cnt;
    logic signed [IN_W-1:0] buf_i, buf_q;
    logic signed [OUT_W-1:0] hold_i, scaled;
    logic [3:0] outst;
    logic chan, rdy_ok;
`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] SMAX = ACC_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;
    logic signed [ACC_W-1:0] shifted;
    assign shifted = fir_dout >>> SHIFT;
    assign scaled  = shifted > SMAX ? OUT_W'(SMAX) : shifted < SMIN ? OUT_W'(SMIN) : OUT_W'(shifted);
`else
    assign scaled = OUT_W'(fir_dout >>> SHIFT);
`endif
    // results are ignored while the core is being cleared or on a stray rdy
    assign rdy_ok = fir_rdy && outst != 4'd0 && !fir_sclr && !flush;
    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        fir_sclr = 1'b0;
        fir_nd   = 1'b0;
        fir_din  = '0;
        case (state)
            CLR: begin
                fir_sclr = 1'b1;
                state_nx = clr_cnt == CW'(CLR_CYC - 1) ? IDLE : CLR;
            end
            IDLE: begin
                in_ready = !flush;
                state_nx = in_valid ? SEND_I : IDLE;
            end
            SEND_I: begin
                fir_din  = buf_i;
                fir_nd   = fir_rfd && !flush;
                state_nx = fir_rfd ? SEND_Q : SEND_I;
            end
            default: begin
                fir_din  = buf_q;
                fir_nd   = fir_rfd && !flush;
                state_nx = fir_rfd ? IDLE : SEND_Q;
            end
        endcase
        if (flush)
            state_nx = CLR;
    end
    always_ff @(posedge clk or posedge sclr) begin
        if (sclr) begin
            state     <= CLR;
            clr_cnt   <= '0;
            buf_i     <= '0;
            buf_q     <= '0;
            hold_i    <= '0;
            outst     <= '0;
            chan      <= 1'b0;
            out_i     <= '0;
            out_q     <= '0;
            out_valid <= 1'b0;
            order_err <= 1'b0;
        end else begin
            state     <= state_nx;
            clr_cnt   <= (state == CLR && state_nx == CLR) ? clr_cnt + 1'b1 : '0;
            out_valid <= 1'b0;
            if (fir_sclr || flush) begin
                buf_i  <= '0;
                buf_q  <= '0;
                hold_i <= '0;
                outst  <= '0;
                chan   <= 1'b0;
            end else begin
                if (in_ready && in_valid) begin
                    buf_i <= in_i;
                    buf_q <= in_q;
                end
                outst <= outst + {3'b0, fir_nd} - {3'b0, rdy_ok};
                if (fir_rdy && outst == 4'd0)
                    order_err <= 1'b1;
                if (rdy_ok) begin
                    chan <= !chan;
                    if (chan) begin
                        out_i     <= hold_i;
                        out_q     <= scaled;
                        out_valid <= 1'b1;
                    end else begin
                        hold_i <= scaled;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_fir_iq_scheduler.sv
// tb_fir_iq_scheduler: FIR core model plus pair-level reference model for fir_iq_scheduler.
// A second instance with SHIFT=13 shares all inputs to exercise narrowing (wrap or FIR_SAT_EN clamp).
module tb_fir_iq_scheduler;
    logic clk = 1'b0, sclr = 1'b1, flush = 1'b0, in_valid = 1'b0;
    logic signed [17:0] in_i = '0, in_q = '0;
    logic fir_rfd = 1'b1, fir_rdy = 1'b0;
    logic signed [33:0] fir_dout = '0;
    logic in_ready, fir_sclr, fir_nd, out_valid, order_err;
    logic signed [17:0] fir_din;
    logic signed [15:0] out_i, out_q;
    logic in_ready_b, fir_sclr_b, fir_nd_b, out_valid_b, order_err_b;
    logic signed [17:0] fir_din_b;
    logic signed [15:0] out_i_b, out_q_b;

    fir_iq_scheduler dut (
        .clk(clk), .sclr(sclr), .flush(flush), .in_i(in_i), .in_q(in_q), .in_valid(in_valid),
        .in_ready(in_ready), .fir_sclr(fir_sclr), .fir_nd(fir_nd), .fir_din(fir_din),
        .fir_rfd(fir_rfd), .fir_rdy(fir_rdy), .fir_dout(fir_dout), .out_i(out_i), .out_q(out_q),
        .out_valid(out_valid), .order_err(order_err)
    );
    fir_iq_scheduler #(.SHIFT(13)) dut13 (
        .clk(clk), .sclr(sclr), .flush(flush), .in_i(in_i), .in_q(in_q), .in_valid(in_valid),
        .in_ready(in_ready_b), .fir_sclr(fir_sclr_b), .fir_nd(fir_nd_b), .fir_din(fir_din_b),
        .fir_rfd(fir_rfd), .fir_rdy(fir_rdy), .fir_dout(fir_dout), .out_i(out_i_b), .out_q(out_q_b),
        .out_valid(out_valid_b), .order_err(order_err_b)
    );

    always #5 clk = ~clk;

    typedef struct {longint due; logic signed [33:0] dout; bit is_q;} res_t;
    typedef struct {int v; bit is_q;} din_t;
    res_t pend[$];
    din_t exp_din[$];
    int pair_i[$], pair_q[$];
    bit rfd_block = 0, rnd_rfd = 0, spur = 0, pulse_due = 0, exp_err = 0, rdy_real = 0, rdy_q = 0;
    int cyc = 0, nd_cnt = 0, acc_cnt = 0, pulse_cnt = 0, tests = 0, fails = 0;
    logic signed [15:0] last_i = '0, last_q = '0, last_i13 = '0, last_q13 = '0;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // core result is din<<15, then the scheduler shifts right by sh and narrows to 16 bits
    function automatic logic signed [15:0] scale(input int v, input int sh);
        longint s;
        s = (longint'(v) <<< 15) >>> sh;
`ifdef FIR_SAT_EN
        if (s > 32767) return 16'sd32767;
        if (s < -32768) return -16'sd32768;
`endif
        return 16'(s);
    endfunction

    always @(negedge clk) begin
        din_t d;
        int pi, pq;
        cyc++;
        fir_rdy = 1'b0;
        fir_dout = '0;
        rdy_real = 0;
        rdy_q = 0;
        if (spur) begin
            fir_rdy = 1'b1;
            fir_dout = 34'sd12345;
        end else if (pend.size() > 0 && pend[0].due == cyc) begin
            fir_rdy = 1'b1;
            fir_dout = pend[0].dout;
            rdy_real = 1;
            rdy_q = pend[0].is_q;
            void'(pend.pop_front());
        end
        fir_rfd = !rfd_block && (!rnd_rfd || $urandom_range(3) != 0);
        rfd_block = 0;
        #4;
        if (sclr) begin
            check("rst_sclr", fir_sclr, 1);
            check("rst_outs", {fir_nd, in_ready, out_valid, order_err, out_i, out_q, fir_din}, 0);
            check("rst_outs13", {out_valid_b, order_err_b, out_i_b, out_q_b}, 0);
            pend.delete();
            exp_din.delete();
            pair_i.delete();
            pair_q.delete();
            exp_err = 0;
            pulse_due = 0;
            last_i = '0; last_q = '0; last_i13 = '0; last_q13 = '0;
        end else begin
            check("out_valid", out_valid, pulse_due);
            check("out_valid13", out_valid_b, pulse_due);
            if (pulse_due) begin
                if (pair_i.size() == 0) begin
                    check("pair_avail", 0, 1);
                end else begin
                    pi = pair_i.pop_front();
                    pq = pair_q.pop_front();
                    last_i = scale(pi, 15); last_q = scale(pq, 15);
                    last_i13 = scale(pi, 13); last_q13 = scale(pq, 13);
                    check("out_i", out_i, last_i);
                    check("out_q", out_q, last_q);
                    check("out_i13", out_i_b, last_i13);
                    check("out_q13", out_q_b, last_q13);
                    pulse_cnt++;
                end
            end else begin
                check("hold", {out_i, out_q, out_i_b, out_q_b}, {last_i, last_q, last_i13, last_q13});
            end
            check("order_err", {order_err, order_err_b}, {exp_err, exp_err});
            check("nd_legal", fir_nd && !(fir_rfd && !fir_sclr), 0);
            if (fir_nd && fir_rfd) begin
                nd_cnt++;
                rfd_block = 1;
                if (exp_din.size() == 0) begin
                    check("nd_extra", 1, 0);
                end else begin
                    d = exp_din.pop_front();
                    check("din", fir_din, d.v);
                    pend.push_back('{due: cyc + 20, dout: 34'(longint'(fir_din) <<< 15), is_q: d.is_q});
                end
            end
            if (in_valid && in_ready) begin
                acc_cnt++;
                pair_i.push_back(int'(in_i));
                pair_q.push_back(int'(in_q));
                exp_din.push_back('{v: int'(in_i), is_q: 0});
                exp_din.push_back('{v: int'(in_q), is_q: 1});
            end
            pulse_due = rdy_real && rdy_q && !flush && !fir_sclr;
            if (fir_rdy && !rdy_real && !flush && !fir_sclr)
                exp_err = 1;
            if (flush) begin
                check("flush_ready", in_ready, 0);
                exp_din.delete();
                pair_i.delete();
                pair_q.delete();
            end
            if (fir_sclr)
                pend.delete();
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic send(input int i, input int q);
        int a = acc_cnt;
        in_i = 18'(i);
        in_q = 18'(q);
        in_valid = 1'b1;
        for (int k = 0; k < 200 && acc_cnt == a; k++)
            step();
        if (acc_cnt == a)
            check("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while ((pend.size() > 0 || exp_din.size() > 0 || pair_i.size() > 0) && k < 500) begin
            step();
            k++;
        end
        if (k >= 500)
            check("drain_timeout", 0, 1);
        step(3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n, p;
        step(3);
        sclr = 1'b0;
        check("rel_sclr1", fir_sclr, 1);
        step();
        check("rel_sclr2", {fir_sclr, in_ready}, 2'b10);
        step();
        check("rel_idle", {fir_sclr, in_ready}, 2'b01);
        check("rel_outs", {fir_nd, out_valid, order_err, out_i, out_q, fir_din}, 0);

        n = nd_cnt; p = pulse_cnt;
        send(1000, -1000);
        drain();
        check("pair1_nd", nd_cnt - n, 2);
        check("pair1_pulses", pulse_cnt - p, 1);
        check("pair1_i", out_i, 1000);
        check("pair1_q", out_q, -1000);

        n = nd_cnt; p = pulse_cnt;
        rnd_rfd = 1;
        for (int k = 0; k < 8; k++)
            send($urandom_range(65535) - 32768, $urandom_range(65535) - 32768);
        drain();
        rnd_rfd = 0;
        check("burst_nd", nd_cnt - n, 16);
        check("burst_pulses", pulse_cnt - p, 8);

        send(131071, -131072);
        drain();
`ifdef FIR_SAT_EN
        check("sat_i13", out_i_b, 32767);
        check("sat_q13", out_q_b, -32768);
`else
        check("wrap_i13", out_i_b, -4);
        check("wrap_q13", out_q_b, 0);
`endif

        send(11, 22);
        n = nd_cnt; p = pulse_cnt;
        step();
        check("flush_i_nd", nd_cnt - n, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_sclr1", fir_sclr, 1);
        step();
        check("flush_sclr2", fir_sclr, 1);
        step();
        check("flush_idle", {fir_sclr, in_ready}, 2'b01);
        step(40);
        check("flush_no_q_nd", nd_cnt - n, 1);
        check("flush_no_pulse", pulse_cnt - p, 0);

        send(5, 7);
        drain();
        check("after_flush_i", out_i, 5);
        check("after_flush_q", out_q, 7);

        rnd_rfd = 1;
        for (int k = 0; k < 40; k++) begin
            send($urandom_range(262143) - 131072, $urandom_range(262143) - 131072);
            step($urandom_range(3));
            if ($urandom_range(9) == 0) begin
                flush = 1'b1;
                step();
                flush = 1'b0;
            end
        end
        drain();
        rnd_rfd = 0;
        check("rand_pairs_left", pair_i.size(), 0);

        spur = 1;
        step();
        spur = 0;
        step(2);
        check("spur_err", {order_err, order_err_b}, 2'b11);
        send(300, -300);
        drain();
        check("spur_next_i", out_i, 300);
        check("spur_next_q", out_q, -300);
        flush = 1'b1;
        step();
        flush = 1'b0;
        step(3);
        check("err_sticky", order_err, 1);

        send(1, 2);
        step(3);
        sclr = 1'b1;
        #1;
        check("async_rst", {fir_sclr, out_valid, order_err, in_ready, fir_nd}, 5'b10000);
        check("async_rst_out", {out_i, out_q}, 0);
        step(2);
        sclr = 1'b0;
        step(3);
        send(9, -9);
        drain();
        check("post_rst_i", out_i, 9);
        check("post_rst_q", out_q, -9);
        check("post_rst_err", order_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
